// File: rtl/display_scan_mux.sv
// Time-multiplexed digit scanner: walks NUM_DIGITS slots of PRESCALE cycles each,
// showing a frame-coherent snapshot of game_status with optional dead time per slot.
module display_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_W      = 3,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] game_status,
  output logic [NUM_DIGITS-1:0]         digit_select,
  output logic [DIGIT_W-1:0]            seven_seg,
  output logic                          frame_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]              pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NUM_DIGITS*DIGIT_W-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]         digit_select_q, digit_select_d;
  logic [DIGIT_W-1:0]            seven_seg_q, seven_seg_d;
  logic                          frame_done_q, frame_done_d;
  logic                          slot_end, frame_end;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pre_cnt_d      = pre_cnt_q;
    idx_d          = idx_q;
    shadow_d       = shadow_q;
    frame_done_d   = 1'b0;
    digit_select_d = '1;
    seven_seg_d    = '0;

    slot_end  = (pre_cnt_q == PRE_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    if (en) begin
      pre_cnt_d = slot_end ? '0 : pre_cnt_q + 1'b1;
      if (slot_end) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (frame_end) begin
        shadow_d     = game_status;
        frame_done_d = 1'b1;
      end
    end

    // Outputs are decoded from next state so the registered copies line up with pre_cnt/idx.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        seven_seg_d = shadow_d[i*DIGIT_W +: DIGIT_W];
        if (en && (int'(pre_cnt_d) >= BLANK_CYCLES)) begin
          digit_select_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      // Parking the counters at their last value makes the first enabled edge start a frame.
      pre_cnt_q      <= PRE_LAST;
      idx_q          <= IDX_LAST;
      // NOTE: the shadow is a plain register bank, so it is reset like any other state.
      shadow_q       <= '0;
      digit_select_q <= '1;
      seven_seg_q    <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      pre_cnt_q      <= pre_cnt_d;
      idx_q          <= idx_d;
      shadow_q       <= shadow_d;
      digit_select_q <= digit_select_d;
      seven_seg_q    <= seven_seg_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign digit_select = digit_select_q;
  assign seven_seg    = seven_seg_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: a small-prescale instance and an 8-digit sweep instance,
// both checked against a model built from enabled-cycle counting.
module tb_display_scan_mux;

  localparam int NA = 4, WA = 3, PA = 4, BA = 1;
  localparam int NB = 8, WB = 4, PB = 2, BB = 0;

  logic              clk_in = 1'b0;
  logic              reset  = 1'b0;
  logic              en     = 1'b0;
  logic [NA*WA-1:0]  gs_a   = '0;
  logic [NB*WB-1:0]  gs_b   = '0;
  logic [NA-1:0]     digit_select_a;
  logic [WA-1:0]     seven_seg_a;
  logic              frame_done_a;
  logic [NB-1:0]     digit_select_b;
  logic [WB-1:0]     seven_seg_b;
  logic              frame_done_b;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: number of enabled edges since reset, last edge's enable, frame snapshots.
  int               k;
  bit               le;
  logic [NA*WA-1:0] sh_a;
  logic [NB*WB-1:0] sh_b;

  always #5 clk_in = ~clk_in;

  display_scan_mux #(.NUM_DIGITS(NA), .DIGIT_W(WA), .PRESCALE(PA), .BLANK_CYCLES(BA)) dut_a (
    .clk_in(clk_in), .reset(reset), .en(en), .game_status(gs_a),
    .digit_select(digit_select_a), .seven_seg(seven_seg_a), .frame_done(frame_done_a)
  );

  display_scan_mux #(.NUM_DIGITS(NB), .DIGIT_W(WB), .PRESCALE(PB), .BLANK_CYCLES(BB)) dut_b (
    .clk_in(clk_in), .reset(reset), .en(en), .game_status(gs_b),
    .digit_select(digit_select_b), .seven_seg(seven_seg_b), .frame_done(frame_done_b)
  );

  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      k    <= 0;
      le   <= 1'b0;
      sh_a <= '0;
      sh_b <= '0;
    end else begin
      le <= en;
      if (en) begin
        k <= k + 1;
        if (k % (NA*PA) == 0) sh_a <= gs_a;
        if (k % (NB*PB) == 0) sh_b <= gs_b;
      end
    end
  end

  function automatic int m_idx(int n, int p);
    return (k == 0) ? n - 1 : ((k - 1) / p) % n;
  endfunction

  function automatic int m_pre(int p);
    return (k == 0) ? p - 1 : (k - 1) % p;
  endfunction

  function automatic logic [7:0] m_sel(int n, int p, int b);
    logic [7:0] s;
    s = '1;
    if (le && k > 0 && ((k - 1) % p) >= b) s[((k - 1) / p) % n] = 1'b0;
    return s;
  endfunction

  function automatic logic m_fd(int n, int p);
    return le && (k > 0) && (((k - 1) % (n*p)) == 0);
  endfunction

  always @(negedge clk_in) begin
    n_cmp++;
    assert ($countones(~digit_select_a) <= 1 && $countones(~digit_select_b) <= 1)
    else begin
      n_err++;
      $display("FAIL one_cold t=%0t: got a=%b b=%b, required at most one zero bit",
               $time, digit_select_a, digit_select_b);
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b0;
    gs_a  = 12'($urandom);
    gs_b  = $urandom;
    repeat (3) @(negedge clk_in);
    n_cmp += 6;
    if (digit_select_a !== 4'hF) begin n_err++; $display("FAIL reset_sel_a: got %b required 1111", digit_select_a); end
    if (seven_seg_a !== 3'd0) begin n_err++; $display("FAIL reset_seg_a: got %0d required 0", seven_seg_a); end
    if (frame_done_a !== 1'b0) begin n_err++; $display("FAIL reset_fd_a: got %b required 0", frame_done_a); end
    if (digit_select_b !== 8'hFF) begin n_err++; $display("FAIL reset_sel_b: got %b required all ones", digit_select_b); end
    if (seven_seg_b !== 4'd0) begin n_err++; $display("FAIL reset_seg_b: got %0d required 0", seven_seg_b); end
    if (frame_done_b !== 1'b0) begin n_err++; $display("FAIL reset_fd_b: got %b required 0", frame_done_b); end
  endtask

  task automatic test_scan();
    logic [3:0] one, e_sel;
    logic [2:0] e_seg;
    logic       e_fd;
    int         pos, pre, idx;
    one   = 4'b0001;
    gs_a  = 12'b101_100_011_010;
    gs_b  = $urandom;
    en    = 1'b1;
    reset = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_in);
      pos   = c - 1;
      pre   = pos % 4;
      idx   = (pos / 4) % 4;
      e_sel = (pre < 1) ? 4'hF : ~(one << idx);
      e_seg = 3'(idx + 2);
      e_fd  = (pos % 16 == 0);
      n_cmp += 3;
      if (digit_select_a !== e_sel) begin n_err++; $display("FAIL scan_sel c=%0d: got %b required %b", c, digit_select_a, e_sel); end
      if (seven_seg_a !== e_seg) begin n_err++; $display("FAIL scan_seg c=%0d: got %0d required %0d", c, seven_seg_a, e_seg); end
      if (frame_done_a !== e_fd) begin n_err++; $display("FAIL scan_fd c=%0d: got %b required %b", c, frame_done_a, e_fd); end
    end
  endtask

  task automatic test_coherency();
    logic [NA*WA-1:0] old;
    logic [2:0]       e_seg;
    bit               seen;
    int               guard;
    guard = 0;
    while (m_idx(NA, PA) != 1 && guard < 32) begin
      @(negedge clk_in);
      guard++;
    end
    old  = sh_a;
    gs_a = 12'hFFF;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (frame_done_a) begin
        seen = 1'b1;
        break;
      end
      e_seg = old[m_idx(NA, PA)*WA +: WA];
      n_cmp++;
      if (seven_seg_a !== e_seg) begin n_err++; $display("FAIL coh_old_seg i=%0d: got %0d required %0d", i, seven_seg_a, e_seg); end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL coh_frame_done: got no pulse within 20 cycles, required one");
    end else begin
      n_cmp++;
      if (seven_seg_a !== 3'd7) begin n_err++; $display("FAIL coh_new_seg: got %0d required 7", seven_seg_a); end
    end
  endtask

  task automatic test_pause();
    logic [7:0] es;
    int  c, guard;
    bit  paused, first_after, seen;
    guard = 0;
    while (!frame_done_a && guard < 40) begin
      @(negedge clk_in);
      guard++;
    end
    c = 0; paused = 1'b0; first_after = 1'b0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!paused && m_idx(NA, PA) == 2 && m_pre(PA) == 2) begin
        en = 1'b0;
        repeat (5) begin
          @(negedge clk_in);
          c++;
          n_cmp += 3;
          if (digit_select_a !== 4'hF) begin n_err++; $display("FAIL pause_sel c=%0d: got %b required 1111", c, digit_select_a); end
          if (frame_done_a !== 1'b0) begin n_err++; $display("FAIL pause_fd c=%0d: got %b required 0", c, frame_done_a); end
          if (seven_seg_a !== sh_a[2*WA +: WA]) begin n_err++; $display("FAIL pause_seg c=%0d: got %0d required %0d", c, seven_seg_a, sh_a[2*WA +: WA]); end
        end
        en = 1'b1;
        paused = 1'b1;
        first_after = 1'b1;
      end
      @(negedge clk_in);
      c++;
      if (first_after) begin
        first_after = 1'b0;
        n_cmp++;
        if (digit_select_a !== 4'b1011) begin n_err++; $display("FAIL resume_sel: got %b required 1011", digit_select_a); end
      end
      es = m_sel(NA, PA, BA);
      n_cmp += 2;
      if (digit_select_a !== es[NA-1:0]) begin n_err++; $display("FAIL pause_model_sel c=%0d: got %b required %b", c, digit_select_a, es[NA-1:0]); end
      if (frame_done_a !== m_fd(NA, PA)) begin n_err++; $display("FAIL pause_model_fd c=%0d: got %b required %b", c, frame_done_a, m_fd(NA, PA)); end
      if (frame_done_a) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!(seen && paused && c == 21)) begin
      n_err++;
      $display("FAIL pause_period: got %0d cycles (seen=%0d paused=%0d) required 21", c, seen, paused);
    end
  endtask

  task automatic test_random();
    logic [7:0] es;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        gs_a = 12'($urandom);
        gs_b = $urandom;
      end
      @(negedge clk_in);
      n_cmp += 6;
      es = m_sel(NA, PA, BA);
      if (digit_select_a !== es[NA-1:0]) begin n_err++; $display("FAIL rand_sel_a i=%0d: got %b required %b", i, digit_select_a, es[NA-1:0]); end
      if (seven_seg_a !== sh_a[m_idx(NA, PA)*WA +: WA]) begin n_err++; $display("FAIL rand_seg_a i=%0d: got %0d required %0d", i, seven_seg_a, sh_a[m_idx(NA, PA)*WA +: WA]); end
      if (frame_done_a !== m_fd(NA, PA)) begin n_err++; $display("FAIL rand_fd_a i=%0d: got %b required %b", i, frame_done_a, m_fd(NA, PA)); end
      es = m_sel(NB, PB, BB);
      if (digit_select_b !== es) begin n_err++; $display("FAIL rand_sel_b i=%0d: got %b required %b", i, digit_select_b, es); end
      if (seven_seg_b !== sh_b[m_idx(NB, PB)*WB +: WB]) begin n_err++; $display("FAIL rand_seg_b i=%0d: got %0d required %0d", i, seven_seg_b, sh_b[m_idx(NB, PB)*WB +: WB]); end
      if (frame_done_b !== m_fd(NB, PB)) begin n_err++; $display("FAIL rand_fd_b i=%0d: got %b required %b", i, frame_done_b, m_fd(NB, PB)); end
    end
  endtask

  task automatic test_sweep_b();
    int last, pulses;
    en = 1'b1;
    last = -1;
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      n_cmp++;
      if ($countones(digit_select_b) != NB - 1) begin n_err++; $display("FAIL sweep_no_blank i=%0d: got %b required exactly one zero", i, digit_select_b); end
      if (frame_done_b) begin
        if (last >= 0) begin
          n_cmp++;
          if (i - last != 16) begin n_err++; $display("FAIL sweep_period: got %0d required 16", i - last); end
        end
        last = i;
        pulses++;
      end
    end
    n_cmp++;
    if (pulses < 3) begin n_err++; $display("FAIL sweep_pulses: got %0d required at least 3", pulses); end
  endtask

  task automatic test_reset_midframe();
    en   = 1'b1;
    gs_a = 12'($urandom);
    repeat (7) @(negedge clk_in);
    #2 reset = 1'b0;
    #1;
    n_cmp += 4;
    if (digit_select_a !== 4'hF) begin n_err++; $display("FAIL async_rst_sel: got %b required 1111", digit_select_a); end
    if (seven_seg_a !== 3'd0) begin n_err++; $display("FAIL async_rst_seg: got %0d required 0", seven_seg_a); end
    if (frame_done_a !== 1'b0) begin n_err++; $display("FAIL async_rst_fd: got %b required 0", frame_done_a); end
    if (digit_select_b !== 8'hFF) begin n_err++; $display("FAIL async_rst_sel_b: got %b required all ones", digit_select_b); end
    @(negedge clk_in);
    n_cmp++;
    if (digit_select_a !== 4'hF) begin n_err++; $display("FAIL held_rst_sel: got %b required 1111", digit_select_a); end
    reset = 1'b1;
    gs_a  = 12'($urandom);
    gs_b  = $urandom;
    @(negedge clk_in);
    n_cmp += 6;
    if (frame_done_a !== 1'b1) begin n_err++; $display("FAIL rst_first_fd: got %b required 1", frame_done_a); end
    if (digit_select_a !== 4'hF) begin n_err++; $display("FAIL rst_first_sel: got %b required 1111", digit_select_a); end
    if (seven_seg_a !== gs_a[WA-1:0]) begin n_err++; $display("FAIL rst_first_seg: got %0d required %0d", seven_seg_a, gs_a[WA-1:0]); end
    if (frame_done_b !== 1'b1) begin n_err++; $display("FAIL rst_first_fd_b: got %b required 1", frame_done_b); end
    if (digit_select_b !== 8'hFE) begin n_err++; $display("FAIL rst_first_sel_b: got %b required 11111110", digit_select_b); end
    if (seven_seg_b !== gs_b[WB-1:0]) begin n_err++; $display("FAIL rst_first_seg_b: got %0d required %0d", seven_seg_b, gs_b[WB-1:0]); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_coherency();
    test_pause();
    test_random();
    test_sweep_b();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, number of scanned digits (legal range 2..8).
REQ-002 The module SHALL have parameter DIGIT_W, default 3, code width per digit.
REQ-003 The module SHALL have parameter PRESCALE, default 1000, clk_in cycles per digit slot (legal range 2..65535).
REQ-004 The module SHALL have parameter BLANK_CYCLES, default 2, dead-time cycles at slot start with all digits off (legal range 0..PRESCALE-1).
REQ-005 The module SHALL have port clk_in, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 The module SHALL have port en, input, 1 bit, scan enable.
REQ-008 The module SHALL have port game_status, input, NUM_DIGITS*DIGIT_W bits; digit i is [i*DIGIT_W +: DIGIT_W].
REQ-009 The module SHALL have port digit_select, output, NUM_DIGITS bits, active-low one-cold digit enable; bit i drives digit i.
REQ-010 The module SHALL have port seven_seg, output, DIGIT_W bits, code for the currently selected digit.
REQ-011 The module SHALL have port frame_done, output, 1 bit, single-cycle pulse on each frame snapshot.

Function
REQ-012 The internal state SHALL be a slot counter pre_cnt (0..PRESCALE-1), a digit index idx (0..NUM_DIGITS-1) and a shadow register holding NUM_DIGITS*DIGIT_W bits.
REQ-013 On an edge with en=1, pre_cnt SHALL increment, wrapping from PRESCALE-1 to 0.
REQ-014 On an edge with en=1 and pre_cnt=PRESCALE-1, idx SHALL advance, wrapping from NUM_DIGITS-1 to 0.
REQ-015 On an edge with en=1, pre_cnt=PRESCALE-1 and idx=NUM_DIGITS-1, the shadow register SHALL load game_status and frame_done SHALL be 1 in the following cycle; frame_done SHALL be 0 in all other cycles.
REQ-016 game_status changes SHALL NOT affect seven_seg until the next shadow load (frame-coherent display).
REQ-017 On an edge with en=0, pre_cnt, idx and shadow SHALL hold, frame_done SHALL be 0 and digit_select SHALL be all ones in the following cycle.
REQ-018 When en returns to 1, scanning SHALL resume from the held pre_cnt/idx with no extra latency.
REQ-019 digit_select SHALL be all ones while pre_cnt < BLANK_CYCLES; otherwise it SHALL be all ones except bit idx = 0.
REQ-020 seven_seg SHALL equal shadow digit idx during every cycle of the slot, blank cycles included.
REQ-021 digit_select, seven_seg and frame_done SHALL be driven directly from flip-flops (computed from next state) so they are glitch-free and aligned with pre_cnt/idx in the same cycle.
REQ-022 No more than one bit of digit_select SHALL ever be 0.
REQ-023 The frame period SHALL be exactly NUM_DIGITS*PRESCALE enabled cycles.

Reset
REQ-024 While reset=0, outputs SHALL be digit_select = all ones, seven_seg = 0, frame_done = 0, independent of clk_in.
REQ-025 While reset=0, internal state SHALL be shadow = 0, pre_cnt = PRESCALE-1, idx = NUM_DIGITS-1.
REQ-026 As a consequence of REQ-025, the first enabled edge after reset release SHALL load shadow, set idx=0, pre_cnt=0, and pulse frame_done.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; no partial state survives.

Verification (NUM_DIGITS=4, DIGIT_W=3, PRESCALE=4, BLANK_CYCLES=1 unless stated)
REQ-028 Reset check: drive reset=0 asynchronously mid-cycle -> digit_select=4'b1111, seven_seg=0, frame_done=0 before the next clock edge.
REQ-029 Scan check: game_status=12'b101_100_011_010, en=1, release reset -> frame_done pulses at cycle 1 and every 16 cycles after.
REQ-030 Scan check, per-slot sequence (REQ-029 stimulus) -> per slot 1 cycle 1111 then 3 cycles of one-cold, in order: 1110/seg 2, 1101/seg 3, 1011/seg 4, 0111/seg 5.
REQ-031 Coherency: change game_status to 12'hFFF during idx=1 -> seven_seg keeps old codes to frame end; new value appears only after the next frame_done.
REQ-032 Pause: drop en for 5 cycles mid-slot at idx=2, pre_cnt=2 -> digit_select=1111 for those cycles; on resume idx=2, pre_cnt=2 continues, frame period extended by 5.
REQ-033 Parameter sweep: NUM_DIGITS=8, DIGIT_W=4, PRESCALE=2, BLANK_CYCLES=0 -> no blank cycles, frame_done every 16 cycles, one-cold invariant holds on every cycle (assertion).
